spi_byte_transmitter: RTL
=========================

SPI_BYTE_TRANSMITTER -- requirements
Module: spi_byte_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per sclk half-period, legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4: number of queued byte entries, a power of two, at least 2.
REQ-003 clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the upstream sequencer offers a byte.
REQ-006 in_data  input  8  the byte to transmit, sent MSB first.
REQ-007 in_dc  input  1  data/command level to drive while this byte is sent.
REQ-008 in_last  input  1  release cs after this byte.
REQ-009 in_ready  output  1  a FIFO slot is free.
REQ-010 sclk  output  1  SPI clock, mode 0 (idles low, slave samples on the rising edge).
REQ-011 mosi  output  1  serial data out.
REQ-012 cs  output  1  chip select, active low.
REQ-013 dc  output  1  data/command line to the display.
REQ-014 busy  output  1  high whenever the state is not IDLE or the FIFO is non-empty.

Function
REQ-015 A transfer is accepted on any clk edge where in_valid and in_ready are both high; {in_last, in_dc, in_data} is then written to the FIFO.
REQ-016 in_ready = !full; a push to a full FIFO is refused even if a pop occurs in the same cycle.
REQ-017 A simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 A tick is a one-cycle pulse every CLK_DIV clk cycles. The prescaler is held at 0 in IDLE and PAUSE and starts counting on the cycle after leaving either state.
REQ-019 States: IDLE, SHIFT, PAUSE, HOLD, GAP.
REQ-020 IDLE, FIFO non-empty: pop one entry; on the next edge drive cs=0, dc=entry dc, mosi=bit7, sclk=0, and enter SHIFT. cs falls 2 clk cycles after the accepting edge when starting from an empty FIFO.
REQ-021 SHIFT: each tick toggles sclk.
REQ-022 SHIFT, on a falling toggle: the shift register advances and mosi presents the next bit.
REQ-023 SHIFT byte end: after the 16th tick (8 rising and 8 falling edges, 16*CLK_DIV cycles) the byte is complete and sclk is 0.
REQ-024 Byte end, entry last=1: enter HOLD.
REQ-025 Byte end, last=0 and FIFO non-empty: pop the next entry on the same edge, update dc and mosi, and stay in SHIFT with cs held low and no idle sclk period.
REQ-026 Byte end, last=0 and FIFO empty: enter PAUSE with cs low and sclk low.
REQ-027 PAUSE: when the FIFO becomes non-empty, behave as IDLE does but keep cs low throughout.
REQ-028 HOLD: wait one tick, then set cs=1 and enter GAP.
REQ-029 GAP: wait one tick, then enter IDLE. cs is high for at least one half-period between frames.
REQ-030 mosi and dc change only while sclk is low or cs is high; they are stable across every rising sclk edge.
REQ-031 Bit count is 3 bits plus a phase bit. The prescaler width is 8 bits and it wraps to 0 at CLK_DIV-1.

Reset
REQ-032 Reset, taking effect on the next edge: state=IDLE, FIFO pointers and count=0, prescaler=0, sclk=0, mosi=0, cs=1, dc=0, busy=0, in_ready=1.
REQ-033 Reset asserted mid-byte: the byte is aborted, cs rises on the next edge, and any queued entries are discarded.
REQ-034 While reset is high, in_valid is ignored and no entry is accepted.

Structure
REQ-035 A shared package spi_pkg holds the state enumeration, the FIFO entry width constant (10), and the default CLK_DIV.
REQ-036 The FIFO is a separate sub-module, byte_fifo (parameters WIDTH and DEPTH; push/pop/full/empty interface).
REQ-037 All outputs are registered; no combinational path exists from the inputs to sclk, mosi, cs or dc.

Verification
REQ-038 CLK_DIV=2: push 0xA5, dc=1, last=1 from reset -> cs falls 2 cycles later; mosi on the 8 rising edges = 1,0,1,0,0,1,0,1; dc=1 throughout; cs rises 32+2 cycles after falling.
REQ-039 Push 0x3C (dc=0, last=0) then 0xFF (dc=1, last=1) back-to-back -> 16 continuous sclk pulses; cs low throughout; dc switches 0->1 at the byte boundary while sclk=0.
REQ-040 Push 0x81 with last=0, then wait 100 cycles, then push 0x7E with last=1 -> PAUSE holds cs=0 and sclk=0 for the wait; both bytes are transmitted in one cs frame.
REQ-041 Hold in_valid high with the serializer stalled -> in_ready drops after 4 accepts, the 5th is refused, and in_ready recovers one cycle after the first pop.
REQ-042 Assert reset after the 3rd rising sclk of a byte with 2 entries queued -> cs=1, sclk=0 next edge; busy=0; no further sclk edges occur.
REQ-043 CLK_DIV=1: push 0x55 with last=1 -> sclk toggles every cycle; mosi = 0,1,0,1,0,1,0,1 at the rising edges.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte transmitter and its entry FIFO.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PAUSE,
    ST_HOLD,
    ST_GAP
  } state_t;

  // FIFO entry layout: {last, dc, data[7:0]}
  localparam int ENTRY_W         = 10;
  localparam int ENTRY_LAST      = 9;
  localparam int ENTRY_DC        = 8;
  localparam int CLK_DIV_DEFAULT = 2;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead FIFO: pop_data always presents the oldest entry while not empty.
module byte_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // a full FIFO refuses a push even when a pop frees a slot on the same edge
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_byte_transmitter.sv
// Queued SPI mode-0 byte transmitter with data/command line and framed chip select.
//
// state | meaning
// IDLE  | cs high; pops the next entry, then launches it a cycle later
// SHIFT | serializing a byte; sclk toggles on every prescaler tick
// PAUSE | frame open (cs low) but FIFO ran dry; launches like IDLE
// HOLD  | last byte sent; cs held low for one more half-period
// GAP   | cs high for one half-period before the next frame
module spi_byte_transmitter
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_dc,
  input  logic       in_last,
  output logic       in_ready,
  output logic       sclk,
  output logic       mosi,
  output logic       cs,
  output logic       dc,
  output logic       busy
);

  state_t               state;
  logic [7:0]           pre;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 cur_dc;
  logic                 cur_last;
  logic                 start_q;

  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 tick;
  logic                 byte_end;
  logic                 idle_pop;
  logic                 chain_pop;

  byte_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_valid),
    .push_data({in_last, in_dc, in_data}),
    .pop      (idle_pop || chain_pop),
    .pop_data (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign tick      = (state inside {ST_SHIFT, ST_HOLD, ST_GAP}) && (pre == 8'(CLK_DIV - 1));
  // sclk doubles as the phase bit: a tick with sclk high is a falling toggle
  assign byte_end  = (state == ST_SHIFT) && tick && sclk && (bit_cnt == 3'd7);
  assign idle_pop  = (state == ST_IDLE || state == ST_PAUSE) && !start_q && !fifo_empty;
  assign chain_pop = byte_end && !cur_last && !fifo_empty;

  assign in_ready  = !fifo_full;
  assign busy      = (state != ST_IDLE) || start_q || !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pre      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cur_dc   <= 1'b0;
      cur_last <= 1'b0;
      start_q  <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      dc       <= 1'b0;
    end else begin
      if (state == ST_IDLE || state == ST_PAUSE || tick) pre <= '0;
      else                                               pre <= pre + 8'd1;

      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (start_q) begin
            start_q <= 1'b0;
            state   <= ST_SHIFT;
            cs      <= 1'b0;
            dc      <= cur_dc;
            mosi    <= shreg[7];
            sclk    <= 1'b0;
            bit_cnt <= '0;
          end else if (idle_pop) begin
            start_q  <= 1'b1;
            shreg    <= fifo_dout[7:0];
            cur_dc   <= fifo_dout[ENTRY_DC];
            cur_last <= fifo_dout[ENTRY_LAST];
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            sclk <= !sclk;
            if (sclk && bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
              mosi    <= shreg[6];
            end else if (byte_end) begin
              if (cur_last) begin
                state <= ST_HOLD;
              end else if (chain_pop) begin
                shreg    <= fifo_dout[7:0];
                cur_dc   <= fifo_dout[ENTRY_DC];
                cur_last <= fifo_dout[ENTRY_LAST];
                dc       <= fifo_dout[ENTRY_DC];
                mosi     <= fifo_dout[7];
                bit_cnt  <= '0;
              end else begin
                state <= ST_PAUSE;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs    <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
